// File: rtl/spi_master_if.sv
// Register-bus bundle for spi_master: one single-cycle access per cycle that cs is high.
interface spi_master_if;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output cs, we, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  cs, we, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/spi_master.sv
// Register-mapped SPI mode-0 master: one byte per DATA write, MSB first,
// SCK half period of DIV+1 clk cycles, software-controlled slave select.
module spi_master #(
  parameter logic [7:0] DEFAULT_DIV = 8'h03
) (
  input  logic         clk,
  input  logic         reset,
  spi_master_if.slave  bus,
  output logic         SPI_SCK,
  output logic         SPI_SS,
  output logic         SPI_MOSI,
  input  logic         SPI_MISO
);

  localparam logic [7:0] AddrCtrl   = 8'h08;
  localparam logic [7:0] AddrStatus = 8'h09;
  localparam logic [7:0] AddrDiv    = 8'h0a;
  localparam logic [7:0] AddrData   = 8'h10;

  typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;

  state_e     state_q, state_d;
  logic [7:0] phase_q, phase_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       sample_q, sample_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] div_q, div_d;
  logic       ss_en_q, ss_en_d;
  logic       overrun_q, overrun_d;

  logic busy, wr, rd, data_wr, phase_done;
  logic unused_wdata;

  assign busy       = (state_q != StIdle);
  assign wr         = bus.cs & bus.we;
  assign rd         = bus.cs & ~bus.we;
  assign data_wr    = wr && (bus.address == AddrData);
  assign phase_done = (phase_q == div_q);
  assign unused_wdata = ^bus.write_data[31:8];

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    sample_d  = sample_q;
    rx_d      = rx_q;
    div_d     = div_q;
    ss_en_d   = ss_en_q;

    // Configuration is frozen while a byte is on the wire.
    if (wr && !busy) begin
      if (bus.address == AddrCtrl) ss_en_d = bus.write_data[0];
      if (bus.address == AddrDiv)  div_d   = bus.write_data[7:0];
    end

    case (state_q)
      StIdle: begin
        if (data_wr) begin
          state_d = StLow;
          shift_d = bus.write_data[7:0];
          phase_d = 8'd0;
          bit_d   = 3'd0;
        end
      end
      StLow: begin
        if (phase_done) begin
          state_d  = StHigh;
          phase_d  = 8'd0;
          sample_d = SPI_MISO;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      StHigh: begin
        if (phase_done) begin
          phase_d = 8'd0;
          // Last bit: shift_q is left alone so MOSI keeps the final tx bit.
          if (bit_q == 3'd7) begin
            state_d = StIdle;
            rx_d    = {shift_q[6:0], sample_q};
          end else begin
            state_d = StLow;
            bit_d   = bit_q + 3'd1;
            shift_d = {shift_q[6:0], sample_q};
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    overrun_d = (data_wr && busy) ||
                (overrun_q && !(rd && (bus.address == AddrStatus)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      phase_q   <= 8'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      sample_q  <= 1'b0;
      rx_q      <= 8'd0;
      div_q     <= DEFAULT_DIV;
      ss_en_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
      rx_q      <= rx_d;
      div_q     <= div_d;
      ss_en_q   <= ss_en_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    bus.read_data = 32'h0;
    if (rd) begin
      case (bus.address)
        AddrCtrl:   bus.read_data = {31'h0, ss_en_q};
        AddrStatus: bus.read_data = {30'h0, overrun_q, busy};
        AddrDiv:    bus.read_data = {24'h0, div_q};
        AddrData:   bus.read_data = {24'h0, rx_q};
        default:    bus.read_data = 32'h0;
      endcase
    end
  end

  assign bus.ready = bus.cs;
  assign SPI_SCK   = (state_q == StHigh);
  assign SPI_SS    = ~ss_en_q;
  assign SPI_MOSI  = shift_q[7];

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter DEFAULT_DIV, default 8'h03, reset value of the clock divider register.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cs  input  1  register access select; one access per cycle cs is high.
REQ-005 SHALL have port we  input  1  write enable, qualified by cs.
REQ-006 SHALL have port address  input  8  word address of register.
REQ-007 SHALL have port write_data  input  32  write data.
REQ-008 SHALL have port read_data  output  32  read data, combinational, valid while cs high and we low.
REQ-009 SHALL have port ready  output  1  access acknowledge.
REQ-010 SHALL have port SPI_SCK  output  1  serial clock, mode 0 (idle low).
REQ-011 SHALL have port SPI_SS  output  1  slave select, active low.
REQ-012 SHALL have port SPI_MOSI  output  1  serial data out, MSB first.
REQ-013 SHALL have port SPI_MISO  input  1  serial data in, MSB first.

Function
REQ-014 SHALL assert ready in the same cycle as cs, for every address, read or write.
REQ-015 SHALL decode registers: 0x08 CTRL (rw, bit0 ss_en), 0x09 STATUS (ro: bit0 busy, bit1 overrun), 0x0a DIV (rw, bits[7:0]), 0x10 DATA (write: tx byte bits[7:0]; read: last rx byte in bits[7:0]).
REQ-016 SHALL return 32'h0 on reads of undefined addresses and ignore writes to them and to STATUS.
REQ-017 SHALL zero-extend all register reads to 32 bits.
REQ-018 SHALL drive SPI_SS = ~ss_en at all times.
REQ-019 SHALL ignore writes to CTRL and DIV while busy.
REQ-020 SHALL implement FSM states IDLE, LOW, HIGH; IDLE -> LOW on DATA write while IDLE.
REQ-021 SHALL, on the DATA write cycle, load the tx byte into the shift register, so that busy=1 and SPI_MOSI=bit7 from the next cycle.
REQ-022 SHALL hold each SCK phase (LOW, HIGH) for DIV+1 clk cycles using an 8-bit phase counter; DIV=0 gives a half period of 1 cycle.
REQ-023 SHALL, on LOW -> HIGH, drive SPI_SCK high and sample SPI_MISO into the shift register LSB.
REQ-024 SHALL, on HIGH -> LOW (bits 1..7), drive SPI_SCK low and shift the next tx bit onto SPI_MOSI.
REQ-025 SHALL, after the 8th HIGH phase, go to IDLE, drive SPI_SCK low, clear busy, latch the received byte into the rx register.
REQ-026 SHALL keep busy high for exactly 16*(DIV+1) cycles per byte.
REQ-027 SHALL, on a DATA write while busy, ignore the data, leave the transfer unaffected, and set overrun.
REQ-028 SHALL clear overrun on a STATUS read; if a read and a new overrun coincide, overrun stays set.
REQ-029 SHALL keep SPI_MOSI at the last transmitted bit while IDLE.
REQ-030 SHALL not gate transfers on ss_en; SS is software controlled.

Reset
REQ-031 SHALL, on reset asserted (asynchronously, any cycle including mid-transfer), set FSM=IDLE, busy=0, overrun=0, ss_en=0, DIV=DEFAULT_DIV, rx=0, shift register=0, phase/bit counters=0.
REQ-032 SHALL, during and after reset, drive SPI_SCK=0, SPI_SS=1, SPI_MOSI=0.
REQ-033 SHALL abort any transfer in progress on reset; the partial rx byte is discarded.

Verification
REQ-034 SHALL cover: after reset, read DIV -> 0x03, STATUS -> 0x0, CTRL -> 0x0, SPI_SS=1, SPI_SCK=0.
REQ-035 SHALL cover: DIV=0, CTRL=1, write DATA 0xA5, MISO model returns 0x3C -> SPI_SS=0, MOSI bits 1,0,1,0,0,1,0,1 at rising edges, busy high 16 cycles, DATA reads 0x3C.
REQ-036 SHALL cover: DIV=3, write DATA 0xFF -> each SCK half period 4 cycles, busy high 64 cycles.
REQ-037 SHALL cover: write DATA 0x11 then DATA 0x22 while busy -> only 0x11 sent, STATUS=0x3; a STATUS read after busy falls returns 0x0.
REQ-038 SHALL cover: write DIV=0x07 while busy -> ignored, DIV reads 0x03; a write after busy falls reads back 0x07.
REQ-039 SHALL cover: reset asserted after 3 bits -> SPI_SCK=0 immediately, busy=0, DATA reads 0x00.
